// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM states shared by alu_seq and its bench.
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SGT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_RSUB = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_MOVZ = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_MFHI = 4'd10;
  localparam logic [3:0] OP_MFLO = 4'd11;
  typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/alu_seq_mul_iter.sv
// mul_iter: unsigned shift-add multiplier, one partial product per clock.
// The first iteration happens on the start edge, so done rises WIDTH-1 cycles later.
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;
  // acc holds {partial high, remaining multiplier bits}; each step adds and shifts right
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] acc, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
    return {s, acc[WIDTH-1:1]};
  endfunction
  always_comb begin
    acc_d = start ? step({{WIDTH{1'b0}}, b}, a) : step(acc_q, a_q);
    done  = run_q && (cnt_q == CW'(WIDTH-1));
    prod  = acc_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      acc_q <= acc_d;
      a_q   <= a;
      cnt_q <= CW'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      run_q <= !done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready issue, iterative MUL into HI/LO.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   codop,
  input  logic [WIDTH-1:0] operando1,
  input  logic [WIDTH-1:0] operando2,
  output logic             out_valid,
  output logic [WIDTH-1:0] resultado,
  output logic             neg,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH-1);
  state_t             state_q, state_d;
  logic [SW-1:0]      step_q, step_d;
  logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d, cry_q, cry_d, ov_q, ov_d;
  logic [WIDTH:0]     add_w, sub_w, rsb_w;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_v, alu_c, alu_ok, fire, is_mul, mul_done;
  logic [2*WIDTH-1:0] prod;
  logic               sa, sb;
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = ~in_ready;
  assign fire      = in_valid & in_ready;
  assign is_mul    = (codop == OP_MUL);
  assign out_valid = ov_q;
  assign resultado = res_q;
  assign neg       = neg_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry     = cry_q;
  assign sa        = operando1[WIDTH-1];
  assign sb        = operando2[WIDTH-1];
  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (fire & is_mul),
    .a     (operando1),
    .b     (operando2),
    .done  (mul_done),
    .prod  (prod)
  );
  always_comb begin
    add_w  = {1'b0, operando1} + {1'b0, operando2};
    sub_w  = {1'b0, operando1} - {1'b0, operando2};
    rsb_w  = {1'b0, operando2} - {1'b0, operando1};
    alu_r  = '0;
    alu_v  = 1'b0;
    alu_c  = 1'b0;
    alu_ok = 1'b1;
    case (codop)
      OP_ADD: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (sa == sb) && (alu_r[WIDTH-1] != sa);
      end
      OP_SUB: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
        alu_v = (sa != sb) && (alu_r[WIDTH-1] != sa);
      end
      OP_RSUB: begin
        alu_r = rsb_w[WIDTH-1:0];
        alu_c = rsb_w[WIDTH];
        alu_v = (sa != sb) && (alu_r[WIDTH-1] != sb);
      end
      OP_SGT:  alu_r = {{(WIDTH-1){1'b0}}, (operando1 > operando2)};
      OP_AND:  alu_r = operando1 & operando2;
      OP_OR:   alu_r = operando1 | operando2;
      OP_XOR:  alu_r = operando1 ^ operando2;
      OP_PASS: alu_r = operando1;
      OP_MOVZ: alu_r = (operando1 == '0) ? operando2 : operando1;
      OP_MFHI: alu_r = hi_q;
      OP_MFLO: alu_r = lo_q;
      default: alu_ok = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    res_d   = res_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    cry_d   = cry_q;
    ov_d    = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_IDLE) begin
      if (fire && is_mul) begin
        state_d = S_MUL;
        step_d  = '0;
      end else if (fire) begin
        ov_d   = 1'b1;
        res_d  = alu_r;
        neg_d  = alu_ok & alu_r[WIDTH-1];
        zero_d = alu_ok & (alu_r == '0);
        ovf_d  = alu_v;
        cry_d  = alu_c;
      end
    end else begin
      // result is registered one cycle before the FSM leaves MUL so out_valid lands on the last busy cycle
      step_d  = step_q + SW'(1);
      state_d = (step_q == LAST) ? S_IDLE : S_MUL;
      if (mul_done) begin
        {hi_d, lo_d} = prod;
        res_d  = prod[WIDTH-1:0];
        neg_d  = prod[WIDTH-1];
        zero_d = (prod[WIDTH-1:0] == '0);
        ovf_d  = 1'b0;
        cry_d  = 1'b0;
        ov_d   = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cry_q   <= 1'b0;
      ov_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      cry_q   <= cry_d;
      ov_q    <= ov_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a reference model and timing checks.
module tb_alu_seq;
  import alu_pkg::*;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   codop = '0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic         in_ready, out_valid, neg, zero, overflow, carry, busy;
  logic [W-1:0] resultado;
  int           total = 0, bad = 0;
  logic [19:0]  sbq[$];
  logic [15:0]  hi_m = '0, lo_m = '0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(W), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codop     (codop),
    .operando1 (op1),
    .operando2 (op2),
    .out_valid (out_valid),
    .resultado (resultado),
    .neg       (neg),
    .zero      (zero),
    .overflow  (overflow),
    .carry     (carry),
    .busy      (busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [31:0] p;
    logic        v, c, fl;
    int          sa, sb, sr;
    sa = $signed(a);
    sb = $signed(b);
    r = '0; v = 1'b0; c = 1'b0; fl = 1'b1;
    case (op)
      OP_ADD:  begin r = a + b; c = (int'(a) + int'(b)) > 65535; sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      OP_SUB:  begin r = a - b; c = a < b; sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      OP_RSUB: begin r = b - a; c = b < a; sr = sb - sa; v = (sr > 32767) || (sr < -32768); end
      OP_SGT:  r = (a > b) ? 16'd1 : 16'd0;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_PASS: r = a;
      OP_MOVZ: r = (a == 0) ? b : a;
      OP_MUL:  begin p = a * b; hi_m = p[31:16]; lo_m = p[15:0]; r = lo_m; end
      OP_MFHI: r = hi_m;
      OP_MFLO: r = lo_m;
      default: fl = 1'b0;
    endcase
    return {r, fl & r[15], fl & (r == 0), v, c};
  endfunction
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_valid = 1'b1; codop = op; op1 = a; op2 = b;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_ready", 32'(in_ready), 32'd1);
    sbq.push_back(model(op, a, b));
    @(posedge clk); #1;
    if (op != OP_MUL) chk("ov_latency", 32'(out_valid), 32'd1);
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (out_valid) begin
      if (sbq.size() == 0) chk("spurious_ov", 32'(out_valid), 32'd0);
      else chk("result", {12'b0, resultado, neg, zero, overflow, carry}, {12'b0, sbq.pop_front()});
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", 32'(resultado), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {28'b0, neg, zero, overflow, carry}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(OP_ADD, 16'h7FFF, 16'h0001);
    idle(1);
    issue(OP_SUB, 16'h0000, 16'h0001);
    issue(OP_RSUB, 16'h0000, 16'h0001);
    idle(1);
    issue(OP_MUL, 16'hFFFF, 16'hFFFF);
    codop = OP_ADD; op1 = 16'h0001; op2 = 16'h0002;
    for (int i = 1; i <= 16; i++) begin
      chk("mul_busy", 32'(in_ready), 32'd0);
      chk("mul_ov", 32'(out_valid), 32'(i == 16));
      if (i == 14) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("mul_ready", 32'(in_ready), 32'd1);
    issue(OP_MFHI, 16'h0000, 16'h0000);
    issue(OP_MFLO, 16'h0000, 16'h0000);
    idle(1);
    issue(OP_MOVZ, 16'h0000, 16'h1234);
    issue(OP_MOVZ, 16'h0005, 16'h1234);
    issue(OP_SGT, 16'h8000, 16'h0001);
    issue(OP_OR, 16'hF0F0, 16'h0F0F);
    issue(OP_PASS, 16'h0000, 16'hBEEF);
    issue(4'd13, 16'h1234, 16'h5678);
    issue(4'd15, 16'hFFFF, 16'hFFFF);
    idle(1);
    issue(OP_MUL, 16'h0003, 16'h0005);
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_res", 32'(resultado), 32'd0);
    sbq.delete();
    hi_m = '0; lo_m = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(OP_MFHI, 16'h0000, 16'h0000);
    issue(OP_MFLO, 16'h0000, 16'h0000);
    idle(1);
    issue(OP_ADD, 16'h1234, 16'h1111);
    issue(OP_XOR, 16'hAAAA, 16'h5555);
    issue(OP_AND, 16'hFF00, 16'h0FF0);
    idle(1);
    for (int i = 0; i < 24; i++) issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    idle(20);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
